// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, mult/div EXE freeze,
// branch flushes and a sticky break/syscall halt. Define STALL_PERF_EN to add stall/flush counters.
module pipeline_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        halt_req,
    output logic        pc_ena,
    output logic        ifid_ena,
    output logic        ifid_flush,
    output logic        idexe_ena,
    output logic        idexe_bubble,
    output logic        exemem_bubble,
    output logic        md_busy,
    output logic        md_done,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next_count;
    logic             r_halt_pending;
    logic             w_next_halt_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_count        <= '0;
            r_halt_pending <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_count        <= w_next_count;
            r_halt_pending <= w_next_halt_pending;
        end
    end

    // A halt decoded while the front end is frozen is remembered and taken when the mult/div retires.
    always_comb begin
        w_next_state        = r_state;
        w_next_count        = r_count;
        w_next_halt_pending = r_halt_pending;
        case (r_state)
            RUN: begin
                if (md_start) begin
                    w_next_state        = MD_WAIT;
                    w_next_count        = md_is_div ? DIV_LOAD : MUL_LOAD;
                    w_next_halt_pending = r_halt_pending | halt_req;
                end else if (halt_req) begin
                    w_next_state = HALT;
                end
            end
            MD_WAIT: begin
                if (r_count != '0) begin
                    w_next_count        = r_count - CNT_W'(1);
                    w_next_halt_pending = r_halt_pending | halt_req;
                end else begin
                    w_next_state        = r_halt_pending ? HALT : RUN;
                    w_next_halt_pending = 1'b0;
                end
            end
            HALT: begin
                w_next_state = HALT;
            end
            default: begin
                w_next_state        = RUN;
                w_next_count        = '0;
                w_next_halt_pending = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_ena        = 1'b0;
        ifid_ena      = 1'b0;
        ifid_flush    = 1'b0;
        idexe_ena     = 1'b0;
        idexe_bubble  = 1'b0;
        exemem_bubble = 1'b0;
        md_busy       = 1'b0;
        md_done       = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (md_start) begin
                        exemem_bubble = 1'b1;
                        md_busy       = 1'b1;
                    end else if (halt_req) begin
                        pc_ena    = 1'b1;
                        ifid_ena  = 1'b1;
                        idexe_ena = 1'b1;
                    end else if (hazard_stall) begin
                        idexe_ena    = 1'b1;
                        idexe_bubble = 1'b1;
                    end else begin
                        pc_ena     = 1'b1;
                        ifid_ena   = 1'b1;
                        idexe_ena  = 1'b1;
                        ifid_flush = branch_taken;
                    end
                end
                MD_WAIT: begin
                    if (r_count != '0) begin
                        exemem_bubble = 1'b1;
                        md_busy       = 1'b1;
                    end else begin
                        pc_ena    = 1'b1;
                        ifid_ena  = 1'b1;
                        idexe_ena = 1'b1;
                        md_done   = 1'b1;
                    end
                end
                HALT: begin
                    ifid_ena   = 1'b1;
                    ifid_flush = 1'b1;
                    idexe_ena  = 1'b1;
                    halted     = 1'b1;
                end
                default: begin
                    pc_ena = 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_ena) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (ifid_flush) r_flush_count <= r_flush_count + 32'd1;
        end
    end

    // Gated so every output reads zero while reset is held.
    assign stall_cycles = rst ? 32'd0 : r_stall_cycles;
    assign flush_count  = rst ? 32'd0 : r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flushc;
    } exp_t;

    logic clk;
    logic rst, hazardStall, branchTaken, mdStart, mdIsDiv, haltReq;
    logic pcEna, ifidEna, ifidFlush, idexeEna, idexeBubble, exememBubble;
    logic mdBusy, mdDone, haltedOut;
    logic [31:0] stallCycles, flushCount;

    exp_t expQ[$];
    int   compared = 0;
    int   mismatched = 0;

    int          mdLeft = 0;
    bit          pendM = 0;
    bit          haltedM = 0;
    logic [31:0] perfStall = '0;
    logic [31:0] perfFlush = '0;

    pipeline_stall_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazardStall), .branch_taken(branchTaken),
        .md_start(mdStart), .md_is_div(mdIsDiv), .halt_req(haltReq),
        .pc_ena(pcEna), .ifid_ena(ifidEna), .ifid_flush(ifidFlush), .idexe_ena(idexeEna),
        .idexe_bubble(idexeBubble), .exemem_bubble(exememBubble), .md_busy(mdBusy),
        .md_done(mdDone), .halted(haltedOut), .stall_cycles(stallCycles), .flush_count(flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl bit order: pc, ifid_ena, ifid_flush, idexe_ena, idexe_bubble, exemem_bubble, busy, done, halted
    task automatic applyStimulus(input logic r, input logic hz, input logic br,
                                 input logic ms, input logic dv, input logic hr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hazardStall = hz; branchTaken = br; mdStart = ms; mdIsDiv = dv; haltReq = hr;
        e = '0;
        if (r) begin
            mdLeft = 0; pendM = 0; haltedM = 0; perfStall = '0; perfFlush = '0;
        end else begin
            e.stall  = perfStall;
            e.flushc = perfFlush;
            if (haltedM) begin
                e.ctrl = 9'b011100001;
            end else if (mdLeft > 1) begin
                e.ctrl = 9'b000001100;
                pendM  = pendM | hr;
                mdLeft = mdLeft - 1;
            end else if (mdLeft == 1) begin
                e.ctrl  = 9'b110100010;
                mdLeft  = 0;
                haltedM = pendM;
                pendM   = 0;
            end else if (ms) begin
                e.ctrl = 9'b000001100;
                mdLeft = (dv ? DIV_N : MUL_N) - 1;
                pendM  = hr;
            end else if (hr) begin
                e.ctrl  = 9'b110100000;
                haltedM = 1;
            end else if (hz) begin
                e.ctrl = 9'b000110000;
            end else if (br) begin
                e.ctrl = 9'b111100000;
            end else begin
                e.ctrl = 9'b110100000;
            end
`ifdef STALL_PERF_EN
            if (!e.ctrl[8]) perfStall = perfStall + 32'd1;
            if (e.ctrl[6]) perfFlush = perfFlush + 32'd1;
`endif
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [8:0] act;
        act = {pcEna, ifidEna, ifidFlush, idexeEna, idexeBubble, exememBubble, mdBusy, mdDone, haltedOut};
        compared++;
        if (act !== e.ctrl) begin
            mismatched++;
            $display("[TB] FAIL ctrl t=%0t actual=%b expected=%b", $time, act, e.ctrl);
        end
        compared++;
        if (stallCycles !== e.stall || flushCount !== e.flushc) begin
            mismatched++;
            $display("[TB] FAIL perf t=%0t actual=%0d/%0d expected=%0d/%0d",
                     $time, stallCycles, flushCount, e.stall, e.flushc);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic r, hz, br, ms, dv, hr;
        rst = 1'b1; hazardStall = 0; branchTaken = 0; mdStart = 0; mdIsDiv = 0; haltReq = 0;

        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        repeat (MUL_N) applyStimulus(0, 0, 0, 1, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < DIV_N; k++)
            applyStimulus(0, 0, (k >= 5 && k < 9), 1, 1, (k == 8));
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 21; k++) applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 2500; n++) begin
            r  = ($urandom_range(0, 59) == 0) || (haltedM && $urandom_range(0, 7) == 0);
            hz = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 3) == 0);
            ms = (mdLeft > 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            dv = ($urandom_range(0, 3) == 0);
            hr = ($urandom_range(0, 24) == 0);
            applyStimulus(r, hz, br, ms, dv, hr);
        end
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage dynamic pipeline. It arbitrates three stall sources and drives the per-stage enable, flush and bubble controls for the PC, IF/ID, ID/EXE and EXE/MEM registers. The sources are the load-use hazard stall, multi-cycle mult/div occupancy of EXE, and branch-taken flushes. It also owns a sticky halt sequence for break/syscall.

Parameters:
MUL_CYCLES, 4, EXE occupancy of a multiply in cycles (must be >= 2)
DIV_CYCLES, 32, EXE occupancy of a divide in cycles (must be >= 2)
CNT_W, 6, width of the occupancy down-counter (must hold DIV_CYCLES-2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
hazard_stall  input  1  load-use stall request from the hazard detector
branch_taken  input  1  branch/jump resolved taken in ID
md_start  input  1  EXE holds a valid mult/div instruction
md_is_div  input  1  qualifies md_start: 1 = divide, 0 = multiply
halt_req  input  1  break/syscall decoded in ID
pc_ena  output  1  PC register write enable
ifid_ena  output  1  IF/ID register write enable
ifid_flush  output  1  clear IF/ID to NOP on next edge
idexe_ena  output  1  ID/EXE register write enable
idexe_bubble  output  1  load NOP into ID/EXE on next edge
exemem_bubble  output  1  load NOP into EXE/MEM on next edge
md_busy  output  1  mult/div unit must hold its operation
md_done  output  1  one-cycle pulse: mult/div result valid this cycle
halted  output  1  pipeline halted (sticky)
stall_cycles  output  32  count of cycles with pc_ena=0 (optional feature)
flush_count  output  32  count of ifid_flush cycles (optional feature)

Behaviour:
- Registered state: RUN, MD_WAIT, HALT. All other outputs are combinational from state, counter and inputs.
- While rst=1:
  - all outputs are 0.
  - On the edge: state<=RUN, counter<=0, halt_pending<=0, perf counters<=0.
  - A reset in MD_WAIT aborts the operation, and md_done does not pulse.
- Priority in RUN: md freeze > halt > hazard_stall > branch_taken > normal flow.
- RUN, normal flow: pc_ena=ifid_ena=idexe_ena=1, all flush/bubble=0.
- RUN with md_start (N = DIV_CYCLES if md_is_div else MUL_CYCLES):
  - Freeze: pc_ena=ifid_ena=idexe_ena=0, exemem_bubble=1, md_busy=1.
  - On the edge: counter<=N-2, state<=MD_WAIT.
- MD_WAIT, counter!=0: same freeze as above; counter decrements each cycle.
- MD_WAIT, counter==0:
  - No freeze: md_done=1, md_busy=0, exemem_bubble=0, enables=1.
  - state<=RUN, or HALT if halt_pending.
  - The instruction therefore occupies EXE for exactly N cycles, with the front end frozen for N-1 of them.
- md_start is ignored in MD_WAIT (the same instruction is still present).
- hazard_stall, branch_taken and halt_req are ignored during freeze, except halt_req, which sets halt_pending.
- Stalled instructions re-present their requests after release.
- RUN with hazard_stall (no md_start): pc_ena=ifid_ena=0, idexe_ena=1, idexe_bubble=1. Stall is asserted in the same cycle as hazard_stall.
- RUN with branch_taken, no stall: ifid_flush=1, enables=1 (PC loads the target).
- branch_taken together with hazard_stall: the stall wins and the flush is suppressed, because the branch is re-evaluated when the stall clears.
- RUN with halt_req (no md_start): state<=HALT.
- HALT:
  - pc_ena=0, ifid_ena=1, ifid_flush=1, idexe_ena=1, halted=1.
  - Older instructions drain; the state is exited only by rst.
- No combinational path from md_start to md_done.

Optional Feature:
STALL_PERF_EN: when defined, stall_cycles increments every cycle with rst=0 and pc_ena=0, and flush_count increments every cycle ifid_flush=1. Both wrap at 2^32 and are cleared by rst. When undefined, both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Release rst, idle inputs: pc_ena=ifid_ena=idexe_ena=1 every cycle. During rst all outputs are 0.
- hazard_stall=1 for 1 cycle: pc_ena=0, ifid_ena=0, idexe_bubble=1 that cycle; normal flow next cycle.
- md_start=1, md_is_div=0 held for 4 cycles (MUL_CYCLES=4): freeze with exemem_bubble=1 for 3 cycles, then md_done=1 on the 4th; md_done never pulses again.
- Divide with branch_taken=1 and halt_req=1 asserted mid-freeze: no ifid_flush during freeze; on md_done the state goes to HALT; halted=1 from the next cycle.
- branch_taken=1 and hazard_stall=1 together: ifid_flush=0, idexe_bubble=1. Next cycle with hazard_stall=0: ifid_flush=1.
- rst asserted at counter=10 in a divide: the next cycle is RUN, md_busy=0, and there is no md_done pulse. With STALL_PERF_EN, stall_cycles equals the frozen cycle count before the reset, then 0.
